tpp_decoder_sync: RTL

- Fully synchronous, parametrised TPP (pulse-position) downlink decoder on the 1.92 MHz baseband clock.
- Synchronises the demodulated envelope `din` and validates the delimiter width.
- Measures the Tcal1 and Tcal2 calibration intervals, then slices each following symbol interval against three derived pivots into 2-bit codes.
- Packs the codes into DATA_W-bit words for the command parser. Replaces the gated-clock, edge-triggered decoder generation and adds timeout, frame-error and partial-word flush behaviour.

---
 rtl/tpp_decoder_sync_if.sv | 44 ++++
 rtl/tpp_decoder_sync.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpp_decoder_sync_if.sv
// ---------------------------------------------------------------------------
// tpp_decoder_sync_if
// Bus bundle between the TPP downlink decoder and its surroundings.
//   master : drives decoder inputs (enable, envelope, parser end flags) and
//            observes the decoded symbol / word / status outputs.
//   slave  : the decoder itself.
// Ports carried:
//   dec_en, din, cmd_end, early_end           -> decoder
//   sym_data, sym_valid, word_data, word_bits,
//   word_valid, delimiter, tc_val, busy,
//   frame_err, dec_done, dec_done_dly         <- decoder
// ---------------------------------------------------------------------------
interface tpp_decoder_sync_if #(
    parameter int CNT_W  = 9,
    parameter int DATA_W = 8
);
    logic                      dec_en;
    logic                      din;
    logic                      cmd_end;
    logic                      early_end;
    logic [1:0]                sym_data;
    logic                      sym_valid;
    logic [DATA_W-1:0]         word_data;
    logic [$clog2(DATA_W):0]   word_bits;
    logic                      word_valid;
    logic                      delimiter;
    logic [CNT_W-2:0]          tc_val;
    logic                      busy;
    logic                      frame_err;
    logic                      dec_done;
    logic                      dec_done_dly;

    modport master (
        output dec_en, din, cmd_end, early_end,
        input  sym_data, sym_valid, word_data, word_bits, word_valid,
               delimiter, tc_val, busy, frame_err, dec_done, dec_done_dly
    );

    modport slave (
        input  dec_en, din, cmd_end, early_end,
        output sym_data, sym_valid, word_data, word_bits, word_valid,
               delimiter, tc_val, busy, frame_err, dec_done, dec_done_dly
    );
endinterface

// File: rtl/tpp_decoder_sync.sv
// ---------------------------------------------------------------------------
// tpp_decoder_sync
// Fully synchronous TPP (pulse-position) downlink decoder.
// Synchronises the envelope, validates the delimiter, measures Tcal1/Tcal2,
// slices every following rise-to-rise interval into a 2-bit symbol and packs
// the symbols MSB-first into DATA_W-bit words. Partial words are flushed when
// the frame ends (parser end flags or an over-long interval).
// Ports:
//   clk_1_92m : baseband clock, all logic on posedge
//   rst       : asynchronous active-high reset
//   bus       : tpp_decoder_sync_if.slave (inputs dec_en/din/cmd_end/
//               early_end, all outputs registered)
// ---------------------------------------------------------------------------
module tpp_decoder_sync #(
    parameter int CNT_W       = 9,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DELIM_MIN   = 20,
    parameter int DELIM_MAX   = 30,
    parameter int TIMEOUT     = 310,
    parameter int DONE_HOLD   = 6
) (
    input  logic                 clk_1_92m,
    input  logic                 rst,
    tpp_decoder_sync_if.slave    bus
);
    localparam int WB_W = $clog2(DATA_W) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DELIM_MIN_C = CNT_W'(DELIM_MIN);
    localparam logic [CNT_W-1:0] DELIM_MAX_C = CNT_W'(DELIM_MAX);
    localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] HOLD_C      = CNT_W'(DONE_HOLD);
    localparam logic [WB_W-1:0]  NSYM_C      = WB_W'(DATA_W / 2);
    localparam logic [WB_W-1:0]  NSYM_ZERO   = {WB_W{1'b0}};
    localparam logic [WB_W-1:0]  NSYM_ONE    = {{(WB_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELIM = 3'd1,
        CAL1  = 3'd2,
        CAL2  = 3'd3,
        DATA  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                state_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                  s_q_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      tcal1_r;
    logic [CNT_W:0]        p1_r, p2_r, p3_r;
    logic [DATA_W-1:0]     pack_r;
    logic [WB_W-1:0]       nsym_r;

    logic [1:0]            sym_data_r;
    logic                  sym_valid_r;
    logic [DATA_W-1:0]     word_data_r;
    logic [WB_W-1:0]       word_bits_r;
    logic                  word_valid_r;
    logic                  delimiter_r;
    logic [CNT_W-2:0]      tc_val_r;
    logic                  busy_r;
    logic                  frame_err_r;
    logic                  dec_done_r;
    logic                  dec_done_dly_r;

    logic                  s_s, rise_s, fall_s;
    logic [CNT_W-1:0]      cnt_inc_s;
    logic [CNT_W:0]        q1_s, q2_s, p1_s, p2_s, p3_s;
    logic [CNT_W:0]        n_ext_s;
    logic [1:0]            sym_s;
    logic [DATA_W-1:0]     sym_word_s;
    logic                  take_sym_s;
    logic [DATA_W-1:0]     pack_nxt_s;
    logic [WB_W-1:0]       nsym_nxt_s;
    logic                  frame_end_s;
    logic                  emit_s;

    assign s_s    = sync_r[SYNC_STAGES-1];
    assign rise_s = s_s & ~s_q_r;
    assign fall_s = ~s_s & s_q_r;

    // Saturating increment of the interval counter.
    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

    // Pivots are formed from the latched Tcal1 and the Tcal2 being measured now.
    assign q1_s = {3'b000, tcal1_r[CNT_W-1:2]};
    assign q2_s = {3'b000, cnt_r[CNT_W-1:2]};
    assign p1_s = q1_s + q2_s;
    assign p2_s = p1_s + q2_s;
    assign p3_s = p2_s + q2_s;

    assign n_ext_s     = {1'b0, cnt_r};
    assign sym_word_s  = {sym_s, {(DATA_W-2){1'b0}}};
    assign take_sym_s  = (state_r == DATA) & rise_s;
    assign frame_end_s = bus.cmd_end | bus.early_end | (cnt_r >= TIMEOUT_C);

    // Slice the current interval against the three pivots.
    always_comb begin
        sym_s = 2'b10;
        if (n_ext_s < p1_r) begin
            sym_s = 2'b00;
        end else if (n_ext_s < p2_r) begin
            sym_s = 2'b01;
        end else if (n_ext_s < p3_r) begin
            sym_s = 2'b11;
        end else begin
            sym_s = 2'b10;
        end
    end

    // Next pack contents, including a symbol decoded this cycle; a word is
    // emitted when full, or on frame end if anything at all is packed.
    always_comb begin
        pack_nxt_s = pack_r;
        nsym_nxt_s = nsym_r;
        if (take_sym_s) begin
            pack_nxt_s = pack_r | (sym_word_s >> {nsym_r, 1'b0});
            nsym_nxt_s = nsym_r + NSYM_ONE;
        end else begin
            pack_nxt_s = pack_r;
            nsym_nxt_s = nsym_r;
        end
        emit_s = (nsym_nxt_s == NSYM_C) | (frame_end_s & (nsym_nxt_s != NSYM_ZERO));
    end

    // Envelope synchroniser and one-clock delay for edge detection.
    always_ff @(posedge clk_1_92m or posedge rst) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b1}};
            s_q_r  <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], bus.din};
            s_q_r  <= s_s;
        end
    end

    // Decoder FSM with interval counter, calibration, packing and status outputs.
    always_ff @(posedge clk_1_92m or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            cnt_r          <= CNT_ZERO;
            tcal1_r        <= CNT_ZERO;
            p1_r           <= {(CNT_W+1){1'b0}};
            p2_r           <= {(CNT_W+1){1'b0}};
            p3_r           <= {(CNT_W+1){1'b0}};
            pack_r         <= {DATA_W{1'b0}};
            nsym_r         <= NSYM_ZERO;
            sym_data_r     <= 2'b00;
            sym_valid_r    <= 1'b0;
            word_data_r    <= {DATA_W{1'b0}};
            word_bits_r    <= {WB_W{1'b0}};
            word_valid_r   <= 1'b0;
            delimiter_r    <= 1'b0;
            tc_val_r       <= {(CNT_W-1){1'b0}};
            busy_r         <= 1'b0;
            frame_err_r    <= 1'b0;
            dec_done_r     <= 1'b0;
            dec_done_dly_r <= 1'b0;
        end else begin
            sym_valid_r    <= 1'b0;
            word_valid_r   <= 1'b0;
            delimiter_r    <= 1'b0;
            frame_err_r    <= 1'b0;
            dec_done_r     <= 1'b0;
            dec_done_dly_r <= 1'b0;
            cnt_r          <= cnt_inc_s;
            if (!bus.dec_en) begin
                // Silent abort: no flush, no status pulses, tc_val kept.
                state_r <= IDLE;
                busy_r  <= 1'b0;
                cnt_r   <= CNT_ZERO;
                pack_r  <= {DATA_W{1'b0}};
                nsym_r  <= NSYM_ZERO;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (fall_s) begin
                            state_r <= DELIM;
                            busy_r  <= 1'b1;
                            cnt_r   <= CNT_ONE;
                        end else begin
                            busy_r  <= 1'b0;
                        end
                    end
                    DELIM: begin
                        if (rise_s) begin
                            cnt_r <= CNT_ONE;
                            if ((cnt_r >= DELIM_MIN_C) && (cnt_r <= DELIM_MAX_C)) begin
                                state_r     <= CAL1;
                                delimiter_r <= 1'b1;
                            end else begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                            end
                        end else if (cnt_r > DELIM_MAX_C) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= DELIM;
                        end
                    end
                    CAL1: begin
                        if (rise_s) begin
                            tcal1_r <= cnt_r;
                            cnt_r   <= CNT_ONE;
                            state_r <= CAL2;
                        end else if (cnt_r >= TIMEOUT_C) begin
                            state_r     <= IDLE;
                            busy_r      <= 1'b0;
                            frame_err_r <= 1'b1;
                        end else begin
                            state_r <= CAL1;
                        end
                    end
                    CAL2: begin
                        if (rise_s) begin
                            cnt_r <= CNT_ONE;
                            if (tcal1_r > cnt_r) begin
                                state_r  <= DATA;
                                tc_val_r <= tcal1_r[CNT_W-1:1] - cnt_r[CNT_W-1:1];
                                p1_r     <= p1_s;
                                p2_r     <= p2_s;
                                p3_r     <= p3_s;
                                pack_r   <= {DATA_W{1'b0}};
                                nsym_r   <= NSYM_ZERO;
                            end else begin
                                state_r     <= IDLE;
                                busy_r      <= 1'b0;
                                frame_err_r <= 1'b1;
                            end
                        end else if (cnt_r >= TIMEOUT_C) begin
                            state_r     <= IDLE;
                            busy_r      <= 1'b0;
                            frame_err_r <= 1'b1;
                        end else begin
                            state_r <= CAL2;
                        end
                    end
                    DATA: begin
                        if (take_sym_s) begin
                            sym_data_r  <= sym_s;
                            sym_valid_r <= 1'b1;
                            cnt_r       <= CNT_ONE;
                        end else begin
                            sym_data_r  <= sym_data_r;
                        end
                        if (emit_s) begin
                            word_data_r  <= pack_nxt_s;
                            word_bits_r  <= {nsym_nxt_s[WB_W-2:0], 1'b0};
                            word_valid_r <= 1'b1;
                            pack_r       <= {DATA_W{1'b0}};
                            nsym_r       <= NSYM_ZERO;
                        end else begin
                            pack_r <= pack_nxt_s;
                            nsym_r <= nsym_nxt_s;
                        end
                        // A rise coincident with the end is already in pack_nxt_s.
                        if (frame_end_s) begin
                            state_r    <= DONE;
                            dec_done_r <= 1'b1;
                            cnt_r      <= CNT_ONE;
                        end else begin
                            state_r <= DATA;
                        end
                    end
                    DONE: begin
                        // The counter is reused as the hold timer; din is ignored.
                        if (cnt_r >= HOLD_C) begin
                            state_r        <= IDLE;
                            busy_r         <= 1'b0;
                            dec_done_dly_r <= 1'b1;
                        end else begin
                            state_r <= DONE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sym_data     = sym_data_r;
    assign bus.sym_valid    = sym_valid_r;
    assign bus.word_data    = word_data_r;
    assign bus.word_bits    = word_bits_r;
    assign bus.word_valid   = word_valid_r;
    assign bus.delimiter    = delimiter_r;
    assign bus.tc_val       = tc_val_r;
    assign bus.busy         = busy_r;
    assign bus.frame_err    = frame_err_r;
    assign bus.dec_done     = dec_done_r;
    assign bus.dec_done_dly = dec_done_dly_r;
endmodule
